// File: rtl/conv_out_tile_scheduler.sv
// Output-tile scheduler for conv_fifo_out_controller: accepts tile descriptors, issues a start pulse,
// gates ddr_en with DDR write-buffer credits and checks the per-tile word count against the descriptor.
module conv_out_tile_scheduler #(
    parameter int CREDITS  = 16,
    parameter int CREDIT_W = 5,
    parameter int WORDS_W  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               desc_valid,
    output logic               desc_ready,
    input  logic [3:0]         desc_mode,
    input  logic [15:0]        desc_ox_start,
    input  logic [15:0]        desc_oy_start,
    input  logic [15:0]        desc_of_start,
    input  logic [15:0]        desc_pox,
    input  logic [15:0]        desc_poy,
    input  logic [15:0]        desc_pof,
    output logic [3:0]         mode,
    output logic [15:0]        cur_ox_start,
    output logic [15:0]        cur_oy_start,
    output logic [15:0]        cur_of_start,
    output logic [15:0]        cur_pox,
    output logic [15:0]        cur_poy,
    output logic [15:0]        cur_pof,
    output logic               conv_fifo_out_start,
    output logic               ddr_en,
    input  logic               valid_conv_out_ddr_adr,
    input  logic               conv_fifo_out_tile_add_end,
    input  logic               ddr_wr_ack,
    output logic               tile_done,
    output logic [WORDS_W-1:0] tile_word_cnt,
    output logic               tile_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(CREDITS);
    localparam logic [CREDIT_W-1:0] CREDIT_MIN_EN = CREDIT_W'(2);

    state_t               state_q;
    logic [CREDIT_W-1:0]  credit_q, credit_d;
    logic [WORDS_W-1:0]   cnt_q, cnt_d;
    logic [WORDS_W-1:0]   expected_q, expected_d;
    logic [WORDS_W-1:0]   word_cnt_q;
    logic [3:0]           mode_q;
    logic [15:0]          ox_q, oy_q, of_q, pox_q, poy_q, pof_q;
    logic                 start_q;
    logic                 done_q;
    logic                 err_q;
    logic                 cnt_inc;
    logic [WORDS_W-1:0]   poy_w, pof_w;

    // Credits track free write-buffer space in every state; a beat and an ack in the same cycle cancel.
    always_comb begin
        credit_d = credit_q;
        if (valid_conv_out_ddr_adr && !ddr_wr_ack && credit_q != '0) begin
            credit_d = credit_q - 1'b1;
        end else if (ddr_wr_ack && !valid_conv_out_ddr_adr && credit_q != CREDIT_MAX) begin
            credit_d = credit_q + 1'b1;
        end
    end

    assign cnt_inc = valid_conv_out_ddr_adr && (state_q == S_RUN || state_q == S_DONE);
    assign cnt_d   = (cnt_inc && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;

    // Mode 0 packs two channels per word; illegal modes expect no words at all.
    always_comb begin
        poy_w      = WORDS_W'(poy_q);
        pof_w      = WORDS_W'(pof_q);
        expected_d = '0;
        if (mode_q == 4'd0) begin
            expected_d = poy_w * (pof_w >> 1);
        end else if (mode_q == 4'd1) begin
            expected_d = poy_w * pof_w;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            credit_q   <= CREDIT_MAX;
            cnt_q      <= '0;
            expected_q <= '0;
            word_cnt_q <= '0;
            mode_q     <= '0;
            ox_q       <= '0;
            oy_q       <= '0;
            of_q       <= '0;
            pox_q      <= '0;
            poy_q      <= '0;
            pof_q      <= '0;
            start_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            credit_q <= credit_d;
            cnt_q    <= cnt_d;
            start_q  <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (desc_valid) begin
                        mode_q  <= desc_mode;
                        ox_q    <= desc_ox_start;
                        oy_q    <= desc_oy_start;
                        of_q    <= desc_of_start;
                        pox_q   <= desc_pox;
                        poy_q   <= desc_poy;
                        pof_q   <= desc_pof;
                        cnt_q   <= '0;
                        err_q   <= 1'b0;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    expected_q <= expected_d;
                    start_q    <= 1'b1;
                    state_q    <= S_START;
                end
                S_START: begin
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    if (conv_fifo_out_tile_add_end) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    word_cnt_q <= cnt_d;
                    err_q      <= (cnt_d != expected_q);
                    done_q     <= 1'b1;
                    state_q    <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // One word of margin: the beat enabled last cycle may still be landing in the buffer.
    assign ddr_en              = (state_q == S_RUN) && (credit_q >= CREDIT_MIN_EN);
    assign desc_ready          = (state_q == S_IDLE);
    assign conv_fifo_out_start = start_q;
    assign tile_done           = done_q;
    assign tile_word_cnt       = word_cnt_q;
    assign tile_err            = err_q;
    assign mode                = mode_q;
    assign cur_ox_start        = ox_q;
    assign cur_oy_start        = oy_q;
    assign cur_of_start        = of_q;
    assign cur_pox             = pox_q;
    assign cur_poy             = poy_q;
    assign cur_pof             = pof_q;

endmodule

// File: tb/tb_conv_out_tile_scheduler.sv
// Directed plus randomized bench for conv_out_tile_scheduler; emulates the out controller and the
// DDR write buffer and checks against a credit/word-count model built from the tile rules.
module tb_conv_out_tile_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        desc_valid;
    logic        desc_ready;
    logic [3:0]  desc_mode;
    logic [15:0] desc_ox_start, desc_oy_start, desc_of_start, desc_pox, desc_poy, desc_pof;
    logic [3:0]  mode;
    logic [15:0] cur_ox_start, cur_oy_start, cur_of_start, cur_pox, cur_poy, cur_pof;
    logic        conv_fifo_out_start;
    logic        ddr_en;
    logic        valid_conv_out_ddr_adr;
    logic        conv_fifo_out_tile_add_end;
    logic        ddr_wr_ack;
    logic        tile_done;
    logic [15:0] tile_word_cnt;
    logic        tile_err;

    int total = 0;
    int bad   = 0;
    int cred  = 16;

    logic [3:0]  nd_mode;
    logic [15:0] nd_ox, nd_oy, nd_of, nd_pox, nd_poy, nd_pof;

    always #5 clk = ~clk;

    conv_out_tile_scheduler #(
        .CREDITS (16),
        .CREDIT_W(5),
        .WORDS_W (16)
    ) dut (
        .clk                       (clk),
        .reset                     (reset),
        .desc_valid                (desc_valid),
        .desc_ready                (desc_ready),
        .desc_mode                 (desc_mode),
        .desc_ox_start             (desc_ox_start),
        .desc_oy_start             (desc_oy_start),
        .desc_of_start             (desc_of_start),
        .desc_pox                  (desc_pox),
        .desc_poy                  (desc_poy),
        .desc_pof                  (desc_pof),
        .mode                      (mode),
        .cur_ox_start              (cur_ox_start),
        .cur_oy_start              (cur_oy_start),
        .cur_of_start              (cur_of_start),
        .cur_pox                   (cur_pox),
        .cur_poy                   (cur_poy),
        .cur_pof                   (cur_pof),
        .conv_fifo_out_start       (conv_fifo_out_start),
        .ddr_en                    (ddr_en),
        .valid_conv_out_ddr_adr    (valid_conv_out_ddr_adr),
        .conv_fifo_out_tile_add_end(conv_fifo_out_tile_add_end),
        .ddr_wr_ack                (ddr_wr_ack),
        .tile_done                 (tile_done),
        .tile_word_cnt             (tile_word_cnt),
        .tile_err                  (tile_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Buffer model: a word leaves a credit, an ack returns one, both together cancel; clamp to 0..16.
    task automatic upd(input bit v, input bit a);
        if (v && !a) cred = (cred > 0) ? cred - 1 : 0;
        else if (a && !v) cred = (cred < 16) ? cred + 1 : 16;
    endtask

    task automatic drive(input bit v, input bit a);
        valid_conv_out_ddr_adr = v;
        ddr_wr_ack             = a;
    endtask

    function automatic logic [15:0] exp_words(input logic [3:0] m, input logic [15:0] poy,
                                              input logic [15:0] pof);
        logic [31:0] p;
        if (m == 4'd0) p = 32'(poy) * 32'(pof / 16'd2);
        else if (m == 4'd1) p = 32'(poy) * 32'(pof);
        else p = 32'd0;
        return p[15:0];
    endfunction

    task automatic idle(input int cycles, input bit v, input bit a);
        for (int i = 0; i < cycles; i++) begin
            check("en_idle", 32'(ddr_en), 32'd0);
            drive(v, a);
            step();
            upd(v, a);
        end
        drive(1'b0, 1'b0);
    endtask

    // Runs one tile from IDLE back to IDLE. n = words the emulated out controller produces,
    // hold = leading RUN cycles with no acks, extra = spurious word in the completion cycle.
    task automatic run_tile(input logic [3:0] m, input logic [15:0] oxs, input logic [15:0] oys,
                            input logic [15:0] ofs, input logic [15:0] pox, input logic [15:0] poy,
                            input logic [15:0] pof, input int n, input int ack_pct, input int hold,
                            input bit extra, input bit present_next);
        int issued, cyc, stall_exp, total_words;
        bit ended, v, a, e;
        logic [15:0] ew;
        ew = exp_words(m, poy, pof);
        check("ready_idle", 32'(desc_ready), 32'd1);
        desc_mode = m; desc_ox_start = oxs; desc_oy_start = oys; desc_of_start = ofs;
        desc_pox = pox; desc_poy = poy; desc_pof = pof; desc_valid = 1'b1;
        step();
        upd(1'b0, 1'b0);
        if (present_next) begin
            desc_mode = nd_mode; desc_ox_start = nd_ox; desc_oy_start = nd_oy;
            desc_of_start = nd_of; desc_pox = nd_pox; desc_poy = nd_poy; desc_pof = nd_pof;
        end else begin
            desc_valid = 1'b0;
        end
        check("ready_load", 32'(desc_ready), 32'd0);
        check("start_load", 32'(conv_fifo_out_start), 32'd0);
        check("err_clr", 32'(tile_err), 32'd0);
        check("done_load", 32'(tile_done), 32'd0);
        check("mode_lat", 32'(mode), 32'(m));
        check("ox_lat", 32'(cur_ox_start), 32'(oxs));
        check("oy_lat", 32'(cur_oy_start), 32'(oys));
        check("of_lat", 32'(cur_of_start), 32'(ofs));
        check("pox_lat", 32'(cur_pox), 32'(pox));
        check("poy_lat", 32'(cur_poy), 32'(poy));
        check("pof_lat", 32'(cur_pof), 32'(pof));
        step();
        check("start_pulse", 32'(conv_fifo_out_start), 32'd1);
        check("en_start", 32'(ddr_en), 32'd0);
        step();
        stall_exp = (cred >= 2) ? cred - 1 : 0;
        if (stall_exp > n) stall_exp = n;
        issued = 0; cyc = 0; ended = 1'b0;
        while (!ended && cyc < 3000) begin
            check("en_run", 32'(ddr_en), 32'(cred >= 2));
            check("start_run", 32'(conv_fifo_out_start), 32'd0);
            check("ox_hold", 32'(cur_ox_start), 32'(oxs));
            check("pof_hold", 32'(cur_pof), 32'(pof));
            if (present_next) check("ready_run", 32'(desc_ready), 32'd0);
            if (hold > 0 && cyc == hold) check("stall_words", 32'(issued), 32'(stall_exp));
            v = ddr_en && (issued < n);
            a = (cyc < hold) ? 1'b0 : ($urandom_range(99) < ack_pct);
            e = (issued + int'(v) == n);
            drive(v, a);
            conv_fifo_out_tile_add_end = e;
            step();
            upd(v, a);
            issued += int'(v);
            cyc++;
            ended = e;
        end
        conv_fifo_out_tile_add_end = 1'b0;
        check("tile_ended", 32'(ended), 32'd1);
        check("en_done", 32'(ddr_en), 32'd0);
        check("done_early", 32'(tile_done), 32'd0);
        v = extra;
        a = ($urandom_range(99) < ack_pct);
        drive(v, a);
        step();
        upd(v, a);
        drive(1'b0, 1'b0);
        total_words = issued + int'(extra);
        check("tile_done", 32'(tile_done), 32'd1);
        check("word_cnt", 32'(tile_word_cnt), 32'(total_words));
        check("tile_err", 32'(tile_err), 32'(16'(total_words) != ew));
        check("ready_back", 32'(desc_ready), 32'd1);
        $display("tile mode=%0d poy=%0d pof=%0d words=%0d expected=%0d err=%0d cycles=%0d",
                 m, poy, pof, total_words, ew, tile_err, cyc);
    endtask

    initial begin
        reset = 1'b0;
        desc_valid = 1'b0; desc_mode = '0;
        desc_ox_start = '0; desc_oy_start = '0; desc_of_start = '0;
        desc_pox = '0; desc_poy = '0; desc_pof = '0;
        drive(1'b0, 1'b0);
        conv_fifo_out_tile_add_end = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(desc_ready), 32'd1);
        check("rst_en", 32'(ddr_en), 32'd0);
        check("rst_start", 32'(conv_fifo_out_start), 32'd0);
        check("rst_done", 32'(tile_done), 32'd0);
        check("rst_cnt", 32'(tile_word_cnt), 32'd0);
        check("rst_err", 32'(tile_err), 32'd0);
        check("rst_mode", 32'(mode), 32'd0);
        check("rst_pof", 32'(cur_pof), 32'd0);
        reset = 1'b1;
        step();

        // Reset in the middle of RUN abandons the tile.
        desc_mode = 4'd1; desc_poy = 16'd2; desc_pof = 16'd8; desc_valid = 1'b1;
        step();
        desc_valid = 1'b0;
        step();
        step();
        check("en_pre_rst", 32'(ddr_en), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("en_in_rst", 32'(ddr_en), 32'd0);
        check("ready_in_rst", 32'(desc_ready), 32'd1);
        check("start_in_rst", 32'(conv_fifo_out_start), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        cred = 16;
        step();
        check("done_after_rst", 32'(tile_done), 32'd0);

        // Beat and ack together at full credit leave it at 16 (stall count below proves it).
        idle(5, 1'b1, 1'b1);
        run_tile(4'd0, 16'd1, 16'd1, 16'd1, 16'd8, 16'd2, 16'd16, 16, 100, 40, 1'b0, 1'b0);
        run_tile(4'd1, 16'd5, 16'd9, 16'd33, 16'd8, 16'd3, 16'd32, 96, 100, 0, 1'b0, 1'b0);

        // Drain to 0 (no underflow), then one ack gives exactly one credit: ddr_en must stay low.
        idle(20, 1'b1, 1'b0);
        idle(1, 1'b0, 1'b1);
        run_tile(4'd1, 16'd2, 16'd2, 16'd2, 16'd8, 16'd1, 16'd4, 4, 60, 10, 1'b0, 1'b0);

        // Spurious word in the completion cycle, then an illegal-mode tile that also clears tile_err.
        run_tile(4'd1, 16'd3, 16'd4, 16'd5, 16'd8, 16'd1, 16'd4, 4, 100, 0, 1'b1, 1'b0);
        check("err_sticky", 32'(tile_err), 32'd1);
        run_tile(4'd2, 16'd7, 16'd7, 16'd7, 16'd8, 16'd3, 16'd3, 2, 80, 0, 1'b0, 1'b0);
        run_tile(4'd5, 16'd7, 16'd7, 16'd7, 16'd8, 16'd3, 16'd3, 0, 80, 0, 1'b0, 1'b0);

        // Back-to-back descriptors: the second waits in desc_valid until the first completes.
        nd_mode = 4'd0; nd_ox = 16'($urandom_range(0, 65535)); nd_oy = 16'($urandom_range(0, 65535));
        nd_of = 16'($urandom_range(0, 65535)); nd_pox = 16'd8;
        nd_poy = 16'($urandom_range(1, 4)); nd_pof = 16'($urandom_range(2, 16));
        run_tile(4'd1, 16'd11, 16'd12, 16'd13, 16'd8, 16'd2, 16'd5, 10, 70, 0, 1'b0, 1'b1);
        run_tile(nd_mode, nd_ox, nd_oy, nd_of, nd_pox, nd_poy, nd_pof,
                 int'(exp_words(nd_mode, nd_poy, nd_pof)), 70, 0, 1'b0, 1'b0);

        for (int t = 0; t < 6; t++) begin
            logic [3:0]  rm;
            logic [15:0] rpoy, rpof;
            rm   = 4'($urandom_range(0, 1));
            rpoy = 16'($urandom_range(1, 4));
            rpof = 16'($urandom_range(1, 16));
            run_tile(rm, 16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                     16'($urandom_range(0, 65535)), 16'($urandom_range(1, 8)), rpoy, rpof,
                     int'(exp_words(rm, rpoy, rpof)), int'($urandom_range(30, 100)), 0,
                     ($urandom_range(3) == 0), 1'b0);
        end

        step();
        check("done_one_cycle", 32'(tile_done), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
